// File: rtl/nanocore_peri_pkg.sv
// Shared types and constants for the NanoCore peripheral bridge.
package nanocore_peri_pkg;

  typedef enum logic [1:0] {
    PB_IDLE,
    PB_ACCESS,
    PB_RESP,
    PB_ERR
  } pb_state_e;

  localparam int unsigned SLOT_MSB = 27;
  localparam int unsigned SLOT_LSB = 24;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/nanocore_peri_bridge.sv
// Bridges single-cycle core peripheral strobes onto a held req/ack slave bus,
// turning decode misses and ack timeouts into error responses.
module nanocore_peri_bridge
  import nanocore_peri_pkg::*;
#(
  parameter int unsigned NUM_SLV   = 4,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_peri_rden,
  input  logic                  i_peri_wren,
  input  logic [31:0]           i_peri_addr,
  input  logic [31:0]           i_peri_wdata,
  input  logic [3:0]            i_peri_wstrb,
  output logic [31:0]           o_peri_rdata,
  output logic                  o_peri_ready,
  output logic                  o_peri_gnt,
  output logic [NUM_SLV-1:0]    o_slv_req,
  output logic                  o_slv_we,
  output logic [23:0]           o_slv_addr,
  output logic [31:0]           o_slv_wdata,
  output logic [3:0]            o_slv_wstrb,
  input  logic [NUM_SLV-1:0]    i_slv_ack,
  input  logic [NUM_SLV*32-1:0] i_slv_rdata,
  output logic                  o_err,
  output logic [31:0]           o_err_addr,
  output logic [7:0]            o_err_cnt,
  output logic                  o_drop
);

  pb_state_e   state;
  logic [3:0]  slot_q;
  logic [31:0] addr_q;
  logic [15:0] wait_q;

  logic        strobe;
  logic [3:0]  req_slot;
  logic        slot_valid;
  logic        ack_sel;
  logic [31:0] rdata_sel;

  assign strobe     = i_peri_rden | i_peri_wren;
  assign req_slot   = i_peri_addr[SLOT_MSB:SLOT_LSB];
  assign slot_valid = 32'(req_slot) < NUM_SLV;

  // Only the latched slot's ack and data matter; other acks are ignored.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < int'(NUM_SLV); k++) begin
      if (slot_q == 4'(k)) begin
        ack_sel   = i_slv_ack[k];
        rdata_sel = i_slv_rdata[32*k +: 32];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= PB_IDLE;
      slot_q       <= '0;
      addr_q       <= '0;
      wait_q       <= '0;
      o_peri_gnt   <= 1'b1;
      o_peri_ready <= 1'b0;
      o_peri_rdata <= '0;
      o_slv_req    <= '0;
      o_slv_we     <= 1'b0;
      o_slv_addr   <= '0;
      o_slv_wdata  <= '0;
      o_slv_wstrb  <= '0;
      o_err        <= 1'b0;
      o_err_addr   <= '0;
      o_err_cnt    <= '0;
      o_drop       <= 1'b0;
    end else begin
      o_peri_ready <= 1'b0;
      o_err        <= 1'b0;
      if (strobe && !o_peri_gnt) o_drop <= 1'b1;

      case (state)
        PB_IDLE: begin
          if (strobe) begin
            slot_q      <= req_slot;
            addr_q      <= i_peri_addr;
            wait_q      <= '0;
            o_slv_addr  <= i_peri_addr[23:0];
            o_slv_wdata <= i_peri_wdata;
            o_slv_wstrb <= i_peri_wstrb;
            o_peri_gnt  <= 1'b0;
            if (slot_valid) begin
              state     <= PB_ACCESS;
              o_slv_req <= NUM_SLV'(1) << req_slot;
              // A simultaneous read and write strobe is a write.
              o_slv_we  <= i_peri_wren;
            end else begin
              state        <= PB_ERR;
              o_peri_ready <= 1'b1;
              o_err        <= 1'b1;
              o_peri_rdata <= ERR_RDATA;
              o_err_addr   <= i_peri_addr;
              if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
            end
          end
        end

        PB_ACCESS: begin
          // An ack on the final wait cycle still wins over the timeout.
          if (ack_sel) begin
            state        <= PB_RESP;
            o_slv_req    <= '0;
            o_slv_we     <= 1'b0;
            o_peri_ready <= 1'b1;
            o_peri_rdata <= rdata_sel;
          end else if (wait_q == 16'(TIMEOUT - 1)) begin
            state        <= PB_ERR;
            o_slv_req    <= '0;
            o_slv_we     <= 1'b0;
            o_peri_ready <= 1'b1;
            o_err        <= 1'b1;
            o_peri_rdata <= ERR_RDATA;
            o_err_addr   <= addr_q;
            if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end

        PB_RESP, PB_ERR: begin
          state      <= PB_IDLE;
          o_peri_gnt <= 1'b1;
        end

        default: state <= PB_IDLE;
      endcase
    end
  end

endmodule
